// File: rtl/pwm_audio_capture_if.sv
// Sample handshake between the PWM capture block and its consumer.
// The producer drives the head sample and valid; the consumer drives ready.
interface pwm_audio_capture_if #(
  parameter int FRAME_BITS = 8
);
  logic [FRAME_BITS-1:0] SAMPLE;
  logic                  SAMPLE_VALID;
  logic                  SAMPLE_READY;

  modport master (output SAMPLE, output SAMPLE_VALID, input  SAMPLE_READY);
  modport slave  (input  SAMPLE, input  SAMPLE_VALID, output SAMPLE_READY);
endinterface

// File: rtl/pwm_audio_capture.sv
// Measures the duty of a free-running PWM audio stream once per frame and
// queues each measurement in a small first-word-fall-through sample FIFO.
module pwm_audio_capture #(
  parameter int FRAME_BITS = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         CLK12,
  input  logic                         RSTb,
  input  logic                         EN,
  input  logic                         PWM_IN,
  pwm_audio_capture_if.master          sample_if,
  output logic                         LOCKED,
  output logic                         OVERFLOW
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [FRAME_BITS-1:0] LAST      = '1;
  localparam logic [FRAME_BITS-1:0] FRAME_ONE = FRAME_BITS'(1);
  localparam logic [FRAME_BITS:0]   HIGH_ONE  = (FRAME_BITS+1)'(1);
  localparam logic [AW:0]           PTR_ONE   = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE} state_t;

  state_t                state;
  logic                  sync1, pin, pin_d, en_d;
  logic                  rise, en_rise;
  logic [FRAME_BITS-1:0] frame_cnt;
  logic [FRAME_BITS:0]   high_cnt, high_next;
  logic                  push;
  logic [FRAME_BITS-1:0] push_data;

  logic [FRAME_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr;
  logic                  empty, full, pop, wr_en;

  assign rise      = pin & ~pin_d;
  assign en_rise   = EN & ~en_d;
  assign high_next = high_cnt + {{FRAME_BITS{1'b0}}, pin};
  // A frame with every cycle high counts 2^FRAME_BITS, one past the sample range.
  assign push_data = high_next[FRAME_BITS] ? '1 : high_next[FRAME_BITS-1:0];
  assign push      = (state == CAPTURE) && EN && (frame_cnt == LAST);

  always_ff @(posedge CLK12 or negedge RSTb) begin
    if (!RSTb) begin
      state     <= IDLE;
      sync1     <= 1'b0;
      pin       <= 1'b0;
      pin_d     <= 1'b0;
      en_d      <= 1'b0;
      frame_cnt <= '0;
      high_cnt  <= '0;
      LOCKED    <= 1'b0;
    end else begin
      sync1 <= PWM_IN;
      pin   <= sync1;
      pin_d <= pin;
      en_d  <= EN;
      case (state)
        IDLE: begin
          frame_cnt <= '0;
          high_cnt  <= '0;
          LOCKED    <= 1'b0;
          if (EN) state <= ARM;
        end
        ARM: begin
          if (!EN) begin
            state <= IDLE;
          end else if (rise) begin
            // The edge cycle itself is frame cycle 0 and is already high.
            state     <= CAPTURE;
            frame_cnt <= FRAME_ONE;
            high_cnt  <= HIGH_ONE;
          end
        end
        CAPTURE: begin
          if (!EN) begin
            state     <= IDLE;
            frame_cnt <= '0;
            high_cnt  <= '0;
            LOCKED    <= 1'b0;
          end else begin
            frame_cnt <= frame_cnt + FRAME_ONE;
            if (frame_cnt == LAST) begin
              high_cnt <= '0;
              LOCKED   <= 1'b1;
            end else begin
              high_cnt <= high_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && sample_if.SAMPLE_READY;
  // A pop on the same edge frees the slot the push lands in.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge CLK12 or negedge RSTb) begin
    if (!RSTb) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      if (en_rise)
        OVERFLOW <= 1'b0;
      else if (push && full && !pop)
        OVERFLOW <= 1'b1;
    end
  end

  always_ff @(posedge CLK12) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign sample_if.SAMPLE       = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign sample_if.SAMPLE_VALID = !empty;
endmodule

// File: tb/tb_pwm_audio_capture.sv
// Directed and randomized checks of pwm_audio_capture against a frame-level
// model: each PWM frame of duty d yields one sample min(d, 255).
module tb_pwm_audio_capture;
  localparam int FB    = 8;
  localparam int DEPTH = 4;
  localparam int FRAME = 256;

  logic CLK12, RSTb, EN, PWM_IN;
  logic LOCKED, OVERFLOW;

  pwm_audio_capture_if #(.FRAME_BITS(FB)) bus ();

  pwm_audio_capture #(.FRAME_BITS(FB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK12    (CLK12),
    .RSTb     (RSTb),
    .EN       (EN),
    .PWM_IN   (PWM_IN),
    .sample_if(bus),
    .LOCKED   (LOCKED),
    .OVERFLOW (OVERFLOW)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int dq[$];     // duties waiting to be played out as PWM frames
  int got[$];    // samples accepted by the consumer
  int exp_q[$];  // expected accepted samples
  int mq[$];     // model FIFO contents
  bit movf;

  initial begin
    CLK12 = 1'b0;
    forever #5 CLK12 = ~CLK12;
  end

  // PWM source: frames of FRAME clocks, high for `duty` clocks from frame start.
  initial begin
    int gpos, gcur;
    bit gact;
    gpos = 0; gcur = 0; gact = 1'b0;
    PWM_IN = 1'b0;
    forever begin
      @(negedge CLK12);
      if (gpos == 0) begin
        if (dq.size() > 0) begin
          gcur = dq.pop_front();
          gact = 1'b1;
        end else begin
          gact = 1'b0;
        end
      end
      PWM_IN = gact && (gpos < gcur);
      if (gact) gpos = (gpos + 1) % FRAME;
    end
  end

  always @(negedge CLK12)
    if (bus.SAMPLE_VALID === 1'b1 && bus.SAMPLE_READY === 1'b1)
      got.push_back(int'(bus.SAMPLE));

  function automatic int sat(int d);
    return (d > FRAME - 1) ? FRAME - 1 : d;
  endfunction

  task automatic tk(input int n);
    repeat (n) begin
      @(posedge CLK12);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk(tag, got[i], exp_q[i]);
    got.delete();
    exp_q.delete();
  endtask

  task automatic model_push(input int d);
    if (mq.size() < DEPTH) mq.push_back(sat(d));
    else movf = 1'b1;
  endtask

  task automatic play(input int d);
    dq.push_back(d);
    exp_q.push_back(sat(d));
  endtask

  initial begin
    RSTb = 1'b0; EN = 1'b0; bus.SAMPLE_READY = 1'b0;
    tk(3);
    chk("rst_sample", bus.SAMPLE, 0);
    chk("rst_valid", bus.SAMPLE_VALID, 0);
    chk("rst_locked", LOCKED, 0);
    chk("rst_overflow", OVERFLOW, 0);
    RSTb = 1'b1;
    tk(3);

    // Steady duty 64 followed by random duties, consumer always ready.
    bus.SAMPLE_READY = 1'b1;
    EN = 1'b1;
    for (int i = 0; i < 4; i++) play(64);
    for (int i = 0; i < 6; i++) play(int'($urandom_range(FRAME, 0)));
    tk(257);
    chk("lock_before_push", LOCKED, 0);
    tk(2);
    chk("lock_after_push", LOCKED, 1);
    chk("first_push_count", got.size(), 1);
    tk(2307);
    EN = 1'b0;
    tk(2);
    chk("t1_locked_off", LOCKED, 0);
    chk("t1_overflow", OVERFLOW, 0);
    cmp_stream("t1_stream");

    // Extreme duties, including constant high and constant low after lock.
    tk(5);
    EN = 1'b1;
    play(100); play(0); play(255); play(FRAME); play(1); play(0); play(0);
    tk(1798);
    EN = 1'b0;
    tk(2);
    cmp_stream("t2_stream");
    chk("t2_locked_off", LOCKED, 0);

    // Consumer stalled: six frames into a four-entry FIFO.
    bus.SAMPLE_READY = 1'b0;
    tk(5);
    EN = 1'b1;
    mq.delete(); movf = 1'b0;
    for (int d = 10; d <= 15; d++) begin
      dq.push_back(d);
      model_push(d);
    end
    tk(1542);
    EN = 1'b0;
    tk(2);
    chk("t3_overflow", OVERFLOW, 32'(movf));
    chk("t3_valid", bus.SAMPLE_VALID, 1);
    chk("t3_head", bus.SAMPLE, mq[0]);
    chk("t3_no_pops", got.size(), 0);
    bus.SAMPLE_READY = 1'b1;
    tk(6);
    exp_q = mq;
    cmp_stream("t3_drain");
    chk("t3_valid_fall", bus.SAMPLE_VALID, 0);
    chk("t3_sample_empty", bus.SAMPLE, 0);
    chk("t3_overflow_sticky", OVERFLOW, 1);

    // Enable dropped mid-frame then restored; the partial frame is lost.
    tk(3);
    EN = 1'b1;
    dq.push_back(50); dq.push_back(60); dq.push_back(70); dq.push_back(80);
    exp_q.push_back(50); exp_q.push_back(70); exp_q.push_back(80);
    tk(1);
    chk("t4_overflow_cleared", OVERFLOW, 0);
    tk(357);
    EN = 1'b0;
    tk(2);
    chk("t4_locked_drop", LOCKED, 0);
    tk(18);
    EN = 1'b1;
    chk("t4_count_at_reenable", got.size(), 1);
    tk(391);
    chk("t4_locked_wait", LOCKED, 0);
    tk(2);
    chk("t4_relock", LOCKED, 1);
    tk(260);
    EN = 1'b0;
    tk(2);
    cmp_stream("t4_stream");

    // Full FIFO with a pop on the very push edge.
    bus.SAMPLE_READY = 1'b0;
    tk(3);
    EN = 1'b1;
    for (int i = 1; i <= 5; i++) play(11 * i);
    tk(1281);
    bus.SAMPLE_READY = 1'b1;
    tk(1);
    bus.SAMPLE_READY = 1'b0;
    tk(3);
    EN = 1'b0;
    tk(2);
    chk("t5_overflow", OVERFLOW, 0);
    chk("t5_head", bus.SAMPLE, 22);
    bus.SAMPLE_READY = 1'b1;
    tk(8);
    cmp_stream("t5_stream");
    chk("t5_valid_fall", bus.SAMPLE_VALID, 0);

    // Reset with samples queued, then a fresh lock.
    bus.SAMPLE_READY = 1'b0;
    tk(3);
    EN = 1'b1;
    dq.push_back(31); dq.push_back(32); dq.push_back(33); dq.push_back(34);
    tk(900);
    chk("t6_valid_pre", bus.SAMPLE_VALID, 1);
    chk("t6_head_pre", bus.SAMPLE, 31);
    chk("t6_locked_pre", LOCKED, 1);
    RSTb = 1'b0;
    #1;
    chk("t6_rst_sample", bus.SAMPLE, 0);
    chk("t6_rst_valid", bus.SAMPLE_VALID, 0);
    chk("t6_rst_locked", LOCKED, 0);
    chk("t6_rst_overflow", OVERFLOW, 0);
    tk(3);
    RSTb = 1'b1;
    tk(3);
    chk("t6_post_valid", bus.SAMPLE_VALID, 0);
    chk("t6_post_sample", bus.SAMPLE, 0);
    tk(300);
    chk("t6_no_edge_no_push", bus.SAMPLE_VALID, 0);
    dq.push_back(77);
    tk(300);
    chk("t6_fresh_valid", bus.SAMPLE_VALID, 1);
    chk("t6_fresh_sample", bus.SAMPLE, 77);
    chk("t6_fresh_locked", LOCKED, 1);
    chk("t6_no_pops", got.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
